// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: DIR/OUT/IN/IRQ registers, 2-flop pad sync, sticky W1C edge interrupts.
// Transfer = SETUP + ACCESS + WAIT_STATES cycles; pready is held low while the wait counter runs.
module apb_gpio_bank #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [3:0]            WS     = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] A_DIR  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_OUT  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_IN   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_IEN  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_POL  = ADDR_WIDTH'(5);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    load_ready;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   dir_r, out_r, ien_r, pol_r, stat_r;
  logic [DATA_WIDTH-1:0]   sync1, sync2, prev;
  logic [DATA_WIDTH-1:0]   rd_q, rd_val, evt, w1c_mask;
  logic                    err_q, bad_addr, err_val, commit;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) state_nxt = SETUP;
      end
      SETUP: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else begin
          state_nxt  = ACCESS;
          cnt_nxt    = WS;
          load_ready = (WS == 4'd0);
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = (psel && !penable) ? SETUP : IDLE;
        end else if (!psel) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt    = cnt - 4'd1;
          load_ready = (cnt == 4'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are captured at SETUP entry so the bus may carry the next setup during pready.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == SETUP) begin
        wr_q    <= pwrite;
        addr_q  <= paddr;
        wdata_q <= pwdata;
      end
      rd_q  <= load_ready ? rd_val  : '0;
      err_q <= load_ready ? err_val : 1'b0;
    end
  end

  always_comb begin
    rd_val   = '0;
    bad_addr = 1'b0;
    case (addr_q)
      A_DIR:   rd_val = dir_r;
      A_OUT:   rd_val = out_r;
      A_IN:    rd_val = sync2;
      A_IEN:   rd_val = ien_r;
      A_STAT:  rd_val = stat_r;
      A_POL:   rd_val = pol_r;
      default: bad_addr = 1'b1;
    endcase
    if (wr_q) rd_val = '0;
    err_val = bad_addr || (wr_q && addr_q == A_IN);
  end

  assign pready   = (state == ACCESS) && (cnt == 4'd0);
  assign commit   = pready && wr_q && !bad_addr && (addr_q != A_IN);
  assign w1c_mask = (commit && addr_q == A_STAT) ? wdata_q : '0;
  assign evt      = (pol_r & sync2 & ~prev) | (~pol_r & ~sync2 & prev);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      dir_r  <= '0;
      out_r  <= '0;
      ien_r  <= '0;
      pol_r  <= '0;
      stat_r <= '0;
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
      // A fresh edge wins over a simultaneous write-1-to-clear.
      stat_r <= (stat_r & ~w1c_mask) | evt;
      if (commit) begin
        case (addr_q)
          A_DIR:   dir_r <= wdata_q;
          A_OUT:   out_r <= wdata_q;
          A_IEN:   ien_r <= wdata_q;
          A_POL:   pol_r <= wdata_q;
          default: ;
        endcase
      end
    end
  end

  assign prdata   = rd_q;
  assign pslverr  = err_q;
  assign gpio_oe  = dir_r;
  assign gpio_out = out_r;
  assign irq      = |(stat_r & ien_r);

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank: one zero-wait-state bank and one three-wait-state bank on a shared bus.
module tb_apb_gpio_bank;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [6:0] paddr = '0;
  logic [7:0] pwdata = '0, gpio_in = '0;
  logic [7:0] prdata_a, prdata_b, gpio_out_a, gpio_out_b, gpio_oe_a, gpio_oe_b;
  logic       pready_a, pready_b, pslverr_a, pslverr_b, irq_a, irq_b;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0, cyc = 0, last_rdy = 0, t1;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .WAIT_STATES(0)) dut (
    .pclk(pclk), .reset(reset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
    .gpio_in(gpio_in), .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a), .irq(irq_a));

  apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .WAIT_STATES(3)) dut_ws (
    .pclk(pclk), .reset(reset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
    .gpio_in(gpio_in), .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b), .irq(irq_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; drives the setup phase immediately.
  // With chain=1 it returns inside the pready cycle so the next call starts a back-to-back setup.
  task automatic xfer(input bit ws, input bit w, input logic [6:0] a, input logic [7:0] d,
                      input logic [7:0] ed, input bit ee, input bit chain, input int lat,
                      input string tag);
    exp_t e, got;
    int   k;
    bit   done;
    e.d = ed;
    e.e = ee;
    sb.push_back(e);
    psel_a = !ws; psel_b = ws; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    tick(1);
    penable = 1'b1;
    k = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(1);
      k++;
      if (ws ? pready_b : pready_a) begin
        done = 1'b1;
        got = sb.pop_front();
        chk({tag, "_prdata"}, ws ? prdata_b : prdata_a, got.d);
        chk({tag, "_pslverr"}, ws ? pslverr_b : pslverr_a, got.e);
        chk({tag, "_latency"}, k, lat);
      end
    end
    if (!done) begin
      got = sb.pop_front();
      chk({tag, "_pready_timeout"}, 0, 1);
    end
    last_rdy = cyc;
    if (!chain) begin
      tick(1);
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    end
  endtask

  initial begin
    // 1: reset state, then reset during the pready cycle of an OUT write
    tick(2);
    chk("rst_prdata", prdata_a, 8'h00);
    chk("rst_pready", pready_a, 1'b0);
    chk("rst_pslverr", pslverr_a, 1'b0);
    chk("rst_gpio_out", gpio_out_a, 8'h00);
    chk("rst_gpio_oe", gpio_oe_a, 8'h00);
    chk("rst_irq", irq_a, 1'b0);
    reset = 1'b0;
    tick(1);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 7'h01; pwdata = 8'hFF;
    tick(1);
    penable = 1'b1;
    tick(1);
    reset = 1'b1;
    #1;
    chk("midrst_pready", pready_a, 1'b0);
    chk("midrst_gpio_out", gpio_out_a, 8'h00);
    tick(1);
    psel_a = 1'b0; penable = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("postrst_gpio_out", gpio_out_a, 8'h00);
    xfer(0, 0, 7'h01, 8'h00, 8'h00, 0, 0, 1, "postrst_rd_out");

    // 2: DIR/OUT write and read-back
    xfer(0, 1, 7'h00, 8'hF0, 8'h00, 0, 0, 1, "wr_dir");
    xfer(0, 1, 7'h01, 8'hA5, 8'h00, 0, 0, 1, "wr_out");
    chk("gpio_oe", gpio_oe_a, 8'hF0);
    chk("gpio_out", gpio_out_a, 8'hA5);
    xfer(0, 0, 7'h00, 8'h00, 8'hF0, 0, 0, 1, "rd_dir");
    xfer(0, 0, 7'h01, 8'h00, 8'hA5, 0, 0, 1, "rd_out");

    // 3: synchronized input and write to read-only IN
    gpio_in = 8'h81;
    tick(2);
    xfer(0, 0, 7'h02, 8'h00, 8'h81, 0, 0, 1, "rd_in");
    xfer(0, 1, 7'h02, 8'h55, 8'h00, 1, 0, 1, "wr_in");
    xfer(0, 0, 7'h02, 8'h00, 8'h81, 0, 0, 1, "rd_in_again");

    // 4: rising-edge interrupts, enable gating and W1C
    xfer(0, 1, 7'h05, 8'hFF, 8'h00, 0, 0, 1, "wr_pol");
    xfer(0, 1, 7'h03, 8'h01, 8'h00, 0, 0, 1, "wr_ien");
    gpio_in = 8'h80;
    tick(4);
    chk("fall_no_irq", irq_a, 1'b0);
    gpio_in = 8'h81;
    tick(4);
    chk("bit0_irq", irq_a, 1'b1);
    xfer(0, 0, 7'h04, 8'h00, 8'h01, 0, 0, 1, "rd_stat_b0");
    xfer(0, 1, 7'h04, 8'h01, 8'h00, 0, 0, 1, "w1c_b0");
    chk("w1c_irq", irq_a, 1'b0);
    gpio_in = 8'h83;
    tick(4);
    xfer(0, 0, 7'h04, 8'h00, 8'h02, 0, 0, 1, "rd_stat_b1");
    chk("b1_masked_irq", irq_a, 1'b0);

    // 5: edge arriving in the same cycle as the W1C commit keeps the bit set
    gpio_in = 8'h82;
    tick(4);
    gpio_in = 8'h83;
    tick(4);
    gpio_in = 8'h82;
    tick(4);
    xfer(0, 0, 7'h04, 8'h00, 8'h03, 0, 0, 1, "rd_stat_pre");
    gpio_in = 8'h83;
    xfer(0, 1, 7'h04, 8'h01, 8'h00, 0, 0, 1, "w1c_race");
    xfer(0, 0, 7'h04, 8'h00, 8'h03, 0, 0, 1, "rd_stat_race");
    chk("race_irq", irq_a, 1'b1);
    xfer(0, 1, 7'h04, 8'h03, 8'h00, 0, 0, 1, "w1c_all");
    xfer(0, 0, 7'h04, 8'h00, 8'h00, 0, 0, 1, "rd_stat_clr");

    // 6: bad address, wait states, back-to-back
    xfer(0, 0, 7'h06, 8'h00, 8'h00, 1, 0, 1, "rd_bad");
    xfer(0, 1, 7'h06, 8'h77, 8'h00, 1, 0, 1, "wr_bad");
    xfer(1, 0, 7'h00, 8'h00, 8'h00, 0, 0, 4, "ws_rd_dir");
    xfer(1, 1, 7'h00, 8'h3C, 8'h00, 0, 1, 4, "ws_b2b_wr");
    t1 = last_rdy;
    xfer(1, 0, 7'h00, 8'h00, 8'h3C, 0, 0, 4, "ws_b2b_rd");
    chk("ws_b2b_gap", last_rdy - t1, 5);
    chk("ws_gpio_oe", gpio_oe_b, 8'h3C);
    chk("ws_untouched_a", gpio_oe_a, 8'hF0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
